// File: rtl/shift_till_one_ctrl_if.sv
// Request/result bundle for the shift-till-one trailing-zero counter.
// The requester drives the word, abort and result acceptance; the controller drives the rest.
interface shift_till_one_ctrl_if #(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  dat;
  logic          clr;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] cnt;
  logic          zero;
  logic          busy;

  modport master (
    output in_valid, dat, clr, out_ready,
    input  in_ready, out_valid, cnt, zero, busy
  );

  modport slave (
    input  in_valid, dat, clr, out_ready,
    output in_ready, out_valid, cnt, zero, busy
  );
endinterface

// File: rtl/shift_till_one_ctrl.sv
// Sequential trailing-zero counter: shifts the latched word right until bit 0 is set.
// Define SHIFT_TILL_ONE_ZERO_SKIP_EN to send an all-zero word straight to DONE.
module shift_till_one_ctrl #(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_till_one_ctrl_if.slave bus
);

`ifdef SHIFT_TILL_ONE_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, nstate;
  logic [W-1:0]  sreg;
  logic [CW-1:0] cnt_q;
  logic          zero_q;
  logic          accept, step, dat_zero;

  assign dat_zero = (bus.dat == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // clr overrides everything, including a simultaneous accept or result handshake
  always_comb begin
    nstate = state;
    accept = 1'b0;
    step   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          nstate = (ZERO_SKIP && dat_zero) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (sreg[0] || cnt_q == CW'(W)) nstate = DONE;
        else                            step   = 1'b1;
      end
      DONE: begin
        if (bus.out_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
    if (bus.clr) begin
      nstate = IDLE;
      accept = 1'b0;
      step   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg   <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
    end else if (bus.clr) begin
      sreg   <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
    end else if (accept) begin
      sreg   <= bus.dat;
      zero_q <= dat_zero;
      cnt_q  <= (ZERO_SKIP && dat_zero) ? CW'(W) : '0;
    end else if (step) begin
      sreg   <= sreg >> 1;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.cnt       = cnt_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_shift_till_one_ctrl.sv
// Directed-vector bench for shift_till_one_ctrl (W=8); expectations are hand-computed.
module tb_shift_till_one_ctrl;
  logic clk;
  logic rst_n;
  int   vec;
  int   err;

  shift_till_one_ctrl_if #(.W(8), .CW(4)) bus ();

  shift_till_one_ctrl #(.W(8), .CW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.dat = '0; bus.clr = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    vec++; if (bus.in_ready !== 1'b1)  begin err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    vec++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    vec++; if (bus.busy !== 1'b0)      begin err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    vec++; if (bus.cnt !== 4'd0)       begin err++; $display("FAIL reset_cnt got=%0d exp=0", bus.cnt); end
    vec++; if (bus.zero !== 1'b0)      begin err++; $display("FAIL reset_zero got=%b exp=0", bus.zero); end
    // Reset in the middle of an operation
    bus.dat = 8'h80; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    vec++; if (bus.busy !== 1'b1) begin err++; $display("FAIL midreset_pre_busy got=%b exp=1", bus.busy); end
    #2 rst_n = 1'b0;
    tick();
    vec++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.cnt !== 4'd0)
      begin err++; $display("FAIL midreset got ov=%b busy=%b ir=%b cnt=%0d exp ov=0 busy=0 ir=1 cnt=0",
                            bus.out_valid, bus.busy, bus.in_ready, bus.cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sweep();
    logic [7:0] dv [7];
    int         ec [7];
    int         lat;
    dv = '{8'h05, 8'h0A, 8'h10, 8'h16, 8'h20, 8'h40, 8'h45};
    ec = '{0, 1, 4, 1, 5, 6, 0};
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      vec++; if (bus.in_ready !== 1'b1) begin err++; $display("FAIL sweep_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      bus.dat = dv[i]; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin tick(); lat++; end
      vec++; if (lat !== ec[i] + 1) begin err++; $display("FAIL sweep_lat[%0d] got=%0d exp=%0d", i, lat, ec[i] + 1); end
      vec++; if (bus.cnt !== 4'(ec[i])) begin err++; $display("FAIL sweep_cnt[%0d] got=%0d exp=%0d", i, bus.cnt, ec[i]); end
      vec++; if (bus.zero !== 1'b0) begin err++; $display("FAIL sweep_zero[%0d] got=%b exp=0", i, bus.zero); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      vec++; if (bus.in_ready !== 1'b1 || bus.cnt !== 4'(ec[i]))
        begin err++; $display("FAIL sweep_idle_hold[%0d] got ir=%b cnt=%0d exp ir=1 cnt=%0d", i, bus.in_ready, bus.cnt, ec[i]); end
    end
  endtask

  task automatic test_zero();
    int lat;
    int exp_lat;
`ifdef SHIFT_TILL_ONE_ZERO_SKIP_EN
    exp_lat = 0;
`else
    exp_lat = 9;
`endif
    bus.dat = 8'h00; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin tick(); lat++; end
    vec++; if (lat !== exp_lat) begin err++; $display("FAIL zero_lat got=%0d exp=%0d", lat, exp_lat); end
    vec++; if (bus.cnt !== 4'd8) begin err++; $display("FAIL zero_cnt got=%0d exp=8", bus.cnt); end
    vec++; if (bus.zero !== 1'b1) begin err++; $display("FAIL zero_flag got=%b exp=1", bus.zero); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    vec++; if (bus.zero !== 1'b1 || bus.busy !== 1'b0)
      begin err++; $display("FAIL zero_idle got zero=%b busy=%b exp zero=1 busy=0", bus.zero, bus.busy); end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.dat = 8'h80; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin tick(); lat++; end
    vec++; if (lat !== 8) begin err++; $display("FAIL bp_lat got=%0d exp=8", lat); end
    for (int i = 0; i < 5; i++) begin
      bus.dat = 8'h01; bus.in_valid = (i % 2 == 0);
      tick();
      vec++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.cnt !== 4'd7)
        begin err++; $display("FAIL bp_hold[%0d] got ov=%b ir=%b cnt=%0d exp ov=1 ir=0 cnt=7",
                              i, bus.out_valid, bus.in_ready, bus.cnt); end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    vec++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cnt !== 4'd7)
      begin err++; $display("FAIL bp_release got ov=%b busy=%b cnt=%0d exp ov=0 busy=0 cnt=7",
                            bus.out_valid, bus.busy, bus.cnt); end
  endtask

  task automatic test_abort();
    bus.dat = 8'h80; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    vec++; if (bus.busy !== 1'b0 || bus.cnt !== 4'd0 || bus.zero !== 1'b0 || bus.out_valid !== 1'b0)
      begin err++; $display("FAIL abort got busy=%b cnt=%0d zero=%b ov=%b exp busy=0 cnt=0 zero=0 ov=0",
                            bus.busy, bus.cnt, bus.zero, bus.out_valid); end
    for (int i = 0; i < 10; i++) begin
      tick();
      vec++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL abort_no_result[%0d] got=%b exp=0", i, bus.out_valid); end
    end
    bus.dat = 8'h01; bus.in_valid = 1'b1; bus.clr = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.clr = 1'b0;
    vec++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
      begin err++; $display("FAIL abort_clr_wins got busy=%b ir=%b exp busy=0 ir=1", bus.busy, bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.dat = 8'h02; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.dat = 8'h04;  // change during SHIFT must not disturb the first result
    lat = 0;
    while (!bus.out_valid && lat < 40) begin tick(); lat++; end
    vec++; if (lat !== 2 || bus.cnt !== 4'd1)
      begin err++; $display("FAIL b2b_first got lat=%0d cnt=%0d exp lat=2 cnt=1", lat, bus.cnt); end
    tick();
    vec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin err++; $display("FAIL b2b_idle got ir=%b ov=%b exp ir=1 ov=0", bus.in_ready, bus.out_valid); end
    tick();
    bus.in_valid = 1'b0;
    vec++; if (bus.busy !== 1'b1) begin err++; $display("FAIL b2b_second_accept got busy=%b exp=1", bus.busy); end
    lat = 0;
    while (!bus.out_valid && lat < 40) begin tick(); lat++; end
    vec++; if (lat !== 3 || bus.cnt !== 4'd2 || bus.zero !== 1'b0)
      begin err++; $display("FAIL b2b_second got lat=%0d cnt=%0d zero=%b exp lat=3 cnt=2 zero=0", lat, bus.cnt, bus.zero); end
    tick();
    bus.out_ready = 1'b0;
    vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL b2b_end got busy=%b exp=0", bus.busy); end
  endtask

  initial begin
    vec = 0;
    err = 0;
    test_reset();
    test_sweep();
    test_zero();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
